// File: rtl/async_fifo_1clk_if.sv
// Write/read handshake bundle for the single-clock FIFO family.
// master = producer/consumer side, slave = the FIFO itself.
interface async_fifo_1clk_if #(
  parameter int DSIZE = 32
) ();
  logic [DSIZE-1:0] write_data;
  logic             write_enable;
  logic             write_full;
  logic             read_enable;
  logic [DSIZE-1:0] read_data;
  logic             read_empty;

  modport master (
    output write_data, write_enable, read_enable,
    input  write_full, read_data, read_empty
  );

  modport slave (
    input  write_data, write_enable, read_enable,
    output write_full, read_data, read_empty
  );
endinterface

// File: rtl/async_fifo_1clk.sv
// Single-clock FIFO, 2**ASIZE x DSIZE, first-word-fall-through read port.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module async_fifo_1clk #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  async_fifo_1clk_if.slave  bus
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

  logic [DSIZE-1:0] mem_r [DEPTH];
  logic [ASIZE:0]   wr_ptr_r;
  logic [ASIZE:0]   rd_ptr_r;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [DSIZE-1:0] head_s;

  // Flags come straight from the registered pointers, no look-ahead.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ASIZE] != rd_ptr_r[ASIZE]) &&
                   (wr_ptr_r[ASIZE-1:0] == rd_ptr_r[ASIZE-1:0]);

  // Requests are qualified by the flags as they stand before the edge.
  assign push_s = bus.write_enable && !full_s;
  assign pop_s  = bus.read_enable && !empty_s;

  // Pointer registers; reset clears both, which empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(ASIZE+1){1'b0}};
      rd_ptr_r <= {(ASIZE+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[ASIZE-1:0]] <= write_data_s();
    end
  end

  function automatic logic [DSIZE-1:0] write_data_s();
    return bus.write_data;
  endfunction

  // Head word is forced to zero while empty so stale storage never leaks out.
  always_comb begin
    head_s = {DSIZE{1'b0}};
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r[ASIZE-1:0]];
    end else begin
      head_s = {DSIZE{1'b0}};
    end
  end

  assign bus.read_data  = head_s;
  assign bus.read_empty = empty_s;
  assign bus.write_full = full_s;
endmodule

// File: tb/tb_async_fifo_1clk.sv
// Directed table-driven bench for async_fifo_1clk plus a few multi-cycle sequences.
module tb_async_fifo_1clk;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  async_fifo_1clk_if #(.DSIZE(32)) bus ();

  async_fifo_1clk #(.DSIZE(32), .ASIZE(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic        e_empty;
    logic        e_full;
    logic [31:0] e_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic we, input logic [31:0] wd, input logic re);
    bus.write_enable = we;
    bus.write_data   = wd;
    bus.read_enable  = re;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic e_empty, input logic e_full,
                             input logic [31:0] e_rd);
    check({tag, ".empty"}, {31'd0, bus.read_empty}, {31'd0, e_empty});
    check({tag, ".full"},  {31'd0, bus.write_full}, {31'd0, e_full});
    check({tag, ".rdata"}, bus.read_data, e_rd);
  endtask

  initial begin
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.write_data   = 32'h0;
    reset_n          = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    check_flags("reset", 1'b1, 1'b0, 32'h0);

    // {we, wd, re, exp_empty, exp_full, exp_read_data} after the edge
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0});        // pop while empty
    vecs.push_back('{1'b1, 32'hA0000001, 1'b0, 1'b0, 1'b0, 32'hA0000001});
    vecs.push_back('{1'b1, 32'hA0000002, 1'b0, 1'b0, 1'b0, 32'hA0000001});
    vecs.push_back('{1'b1, 32'hA0000003, 1'b0, 1'b0, 1'b0, 32'hA0000001});
    vecs.push_back('{1'b1, 32'hA0000004, 1'b0, 1'b0, 1'b1, 32'hA0000001});
    vecs.push_back('{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hA0000001}); // overflow ignored
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA0000002});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA0000003});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA0000004});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0});        // underflow ignored
    vecs.push_back('{1'b1, 32'h000000AA, 1'b1, 1'b0, 1'b0, 32'h000000AA}); // empty + push + pop
    vecs.push_back('{1'b1, 32'h000000BB, 1'b0, 1'b0, 1'b0, 32'h000000AA});
    vecs.push_back('{1'b1, 32'h000000CC, 1'b1, 1'b0, 1'b0, 32'h000000BB}); // mid + push + pop
    vecs.push_back('{1'b1, 32'h000000DD, 1'b0, 1'b0, 1'b0, 32'h000000BB});
    vecs.push_back('{1'b1, 32'h000000EE, 1'b0, 1'b0, 1'b1, 32'h000000BB}); // full: BB CC DD EE
    vecs.push_back('{1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0, 32'h000000CC}); // full + push + pop
    vecs.push_back('{1'b1, 32'h00000011, 1'b0, 1'b0, 1'b1, 32'h000000CC}); // back to 4
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h000000DD});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h000000EE});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00000011});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re);
      check_flags($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full, vecs[i].e_rd);
    end

    // Alternating traffic against a queue model, two rounds of 32 cycles.
    for (int rep = 0; rep < 2; rep++) begin
      for (int cyc = 0; cyc < 32; cyc++) begin
        logic        we;
        logic        re;
        logic [31:0] wd;
        int          pre;
        we  = (cyc % 2) == 0;
        wd  = $urandom;
        re  = model_q.size() != 0;
        pre = model_q.size();
        check($sformatf("alt%0d_%0d.empty", rep, cyc), {31'd0, bus.read_empty},
              {31'd0, pre == 0});
        check($sformatf("alt%0d_%0d.rdata", rep, cyc), bus.read_data,
              (pre == 0) ? 32'h0 : model_q[0]);
        step(we, wd, re);
        if (re && pre > 0) void'(model_q.pop_front());
        if (we && pre < 4) model_q.push_back(wd);
      end
    end
    while (model_q.size() != 0) begin
      check("drain.rdata", bus.read_data, model_q[0]);
      step(1'b0, 32'h0, 1'b1);
      void'(model_q.pop_front());
    end
    check_flags("drained", 1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges with two words stored.
    step(1'b1, 32'h55550001, 1'b0);
    step(1'b1, 32'h55550002, 1'b0);
    check_flags("pre_rst", 1'b0, 1'b0, 32'h55550001);
    #2 reset_n = 1'b0;
    #1 check_flags("mid_rst", 1'b1, 1'b0, 32'h0);
    #1 reset_n = 1'b1;
    step(1'b1, 32'h12345678, 1'b0);
    check_flags("post_rst", 1'b0, 1'b0, 32'h12345678);
    step(1'b0, 32'h0, 1'b1);
    check_flags("post_rst_pop", 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/async_fifo_1clk.md
Name: async_fifo_1clk

Overview:
- Parameterised FIFO buffer: DSIZE-bit words, depth 2**ASIZE.
- Single clock; asynchronous active-low reset.
- First-word-fall-through read port: the head word is always visible on read_data while the FIFO is non-empty.
- Sits between a producer and a consumer sharing one clock domain; uses the same write/read port naming as the codebase's FIFO family.

Parameters:
- DSIZE, 32, data word width in bits.
- ASIZE, 2, address width; depth = 2**ASIZE entries (default 4).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- write_data  input  DSIZE  word to push.
- write_enable  input  1  push request, sampled on the rising edge of clk.
- write_full  output  1  high when the FIFO holds 2**ASIZE words.
- read_enable  input  1  pop request, sampled on the rising edge of clk.
- read_data  output  DSIZE  current head word (FWFT); 0 while empty.
- read_empty  output  1  high when the FIFO holds 0 words.

Behaviour:
- Interface: one clock (clk); reset (reset_n) is asynchronous and active-low.
- Storage: 2**ASIZE x DSIZE register array. Storage is not reset.
- Pointers: wr_ptr and rd_ptr, each ASIZE+1 bits binary.
  - The low ASIZE bits address storage.
  - The MSB is the wrap bit.
- Reset: asserting reset_n low clears wr_ptr and rd_ptr to 0 immediately, independent of clk.
  - Outputs then read write_full=0, read_empty=1, read_data=0.
  - Resetting mid-operation discards all contents; storage values are don't-care afterwards.
- Push: on the rising edge of clk, if write_enable=1 and write_full=0:
  - mem[wr_ptr[ASIZE-1:0]] <= write_data;
  - wr_ptr <= wr_ptr+1.
  - write_enable while full is ignored: no storage write, no pointer change, no error flag.
- Pop: on the rising edge of clk, if read_enable=1 and read_empty=0, rd_ptr <= rd_ptr+1.
  - read_enable while empty is ignored.
- read_data: combinational mem[rd_ptr[ASIZE-1:0]] when read_empty=0, else 0.
  - The word is valid in the same cycle the consumer decides to pop.
  - After a pop, the next word appears the cycle after the edge.
- Flags: combinational from the registered pointers.
  - read_empty = (wr_ptr == rd_ptr).
  - write_full = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) and (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]).
  - Flags change only after a clock edge or reset; no same-cycle look-ahead.
- Simultaneous push and pop in one cycle: each is qualified independently by the flags as they stand before the edge.
  - Not full and not empty: both occur and occupancy is unchanged.
  - Full: only the pop occurs; the push is dropped.
  - Empty: only the push occurs; read_data shows the new word on the next cycle.
- Wrap-around: pointers increment modulo 2**(ASIZE+1). Ordering is strictly first-in first-out across any number of wraps.
- Data integrity: every accepted word is returned exactly once, unmodified, in acceptance order.

Test Plan:
- Reset then idle: hold reset_n=0 for 5 cycles, release → read_empty=1, write_full=0, read_data=0; read_enable=1 with no writes leaves read_empty=1.
- Fill and overflow: push 0xA0000001..0xA0000004 on 4 consecutive cycles → write_full=1 after the 4th edge. A 5th push of 0xDEADBEEF is ignored, and read_data=0xA0000001.
- Drain in order: from full, pop 4 times → read_data sequence 0xA0000001, ...02, ...03, ...04 with write_full=0 after the first pop. read_empty=1 after the 4th pop, and a further pop leaves pointers unchanged.
- Alternating traffic with wrap: 32 cycles pushing random words on even cycles, with the consumer popping whenever non-empty, repeated twice (64+ pointer increments) → every popped value equals a golden queue model; no loss or duplication.
- Simultaneous push/pop at boundaries:
  - Full + push + pop → occupancy 3, then 4 after the next plain push.
  - Empty + push + pop → occupancy 1 with read_data = pushed word.
  - Mid-level + push + pop → occupancy constant.
- Reset mid-operation: with 2 words stored, pulse reset_n low between clock edges → read_empty=1 and read_data=0 immediately. A following push of 0x12345678 then reads back 0x12345678.
